axi4lite_reg_bank: RTL

Parametrised AXI4-Lite slave register bank. It generalises the single-purpose generated register slaves to NUM_REGS registers of DATA_WIDTH bits, each either read-write or read-only. Unlike those slaves, it honours WSTRB byte enables and returns SLVERR for out-of-range or illegal accesses. It sits between the AXI4-Lite interconnect and user logic, exposing flattened register outputs, read-only inputs and per-register write pulses.

---
 rtl/axi4lite_reg_bank.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/axi4lite_reg_bank.sv
// AXI4-Lite slave register bank with NUM_REGS registers of DATA_WIDTH bits.
// Each register is read-write (internal storage, WSTRB byte enables) or
// read-only (sourced from regs_i). Illegal or out-of-range accesses get SLVERR.
// Write and read channels are independent; each allows one outstanding
// transaction.
module axi4lite_reg_bank #(
  parameter int unsigned            NUM_REGS    = 8,
  parameter int unsigned            DATA_WIDTH  = 32,
  parameter int unsigned            ADDR_WIDTH  = 5,
  parameter logic [NUM_REGS-1:0]    RO_MASK     = '0,
  parameter logic [DATA_WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic                           aclk,
  input  logic                           areset,
  // write address channel
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic [2:0]                     awprot,
  // write data channel
  input  logic                           wvalid,
  output logic                           wready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  // write response channel
  output logic                           bvalid,
  input  logic                           bready,
  output logic [1:0]                     bresp,
  // read address channel
  input  logic                           arvalid,
  output logic                           arready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic [2:0]                     arprot,
  // read data channel
  output logic                           rvalid,
  input  logic                           rready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  // user-logic side
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] regs_i,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);
  localparam int unsigned IDX_W  = ADDR_WIDTH - OFF_W;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // write channel
  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q,  w_held_d;
  logic [IDX_W-1:0]      aw_idx_q,  aw_idx_d;
  logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
  logic [STRB_W-1:0]     wstrb_q,   wstrb_d;
  logic                  bvalid_q,  bvalid_d;
  logic [1:0]            bresp_q,   bresp_d;
  logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;

  // register storage (read-only slots keep their reset value and are never used)
  logic [DATA_WIDTH-1:0] reg_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] reg_d [NUM_REGS];

  // read channel
  logic                  ar_busy_q, ar_busy_d;
  logic                  rvalid_q,  rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
  logic [1:0]            rresp_q,   rresp_d;

  // combinational helpers
  logic                  commit;
  logic [IDX_W-1:0]      ar_idx;
  logic [DATA_WIDTH-1:0] rd_value;
  logic [1:0]            rd_resp;

  // Protection bits and sub-word address bits carry no meaning for this bank.
  logic unused_ok;
  assign unused_ok = ^{awprot, arprot, awaddr[OFF_W-1:0], araddr[OFF_W-1:0], regs_i};

  // ---------------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------------
  assign commit = aw_held_q & w_held_q & ~bvalid_q;

  // Capture AW/W independently, commit once both are held, release on B handshake.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves
    // it unassigned and no latch is inferred.
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    aw_idx_d   = aw_idx_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    wr_pulse_d = '0;
    reg_d      = reg_q;

    if (awvalid && !aw_held_q) begin
      aw_held_d = 1'b1;
      aw_idx_d  = awaddr[ADDR_WIDTH-1:OFF_W];
    end

    if (wvalid && !w_held_q) begin
      w_held_d = 1'b1;
      wdata_d  = wdata;
      wstrb_d  = wstrb;
    end

    if (commit) begin
      bvalid_d = 1'b1;
      bresp_d  = RESP_SLVERR;
      for (int k = 0; k < int'(NUM_REGS); k++) begin
        if (aw_idx_q == IDX_W'(k) && !RO_MASK[k]) begin
          bresp_d       = RESP_OKAY;
          wr_pulse_d[k] = 1'b1;
          for (int b = 0; b < int'(STRB_W); b++) begin
            if (wstrb_q[b]) begin
              reg_d[k][8*b +: 8] = wdata_q[8*b +: 8];
            end
          end
        end
      end
    end

    // Flags stay held until the response is taken, so only one write is in flight.
    if (bvalid_q && bready) begin
      bvalid_d  = 1'b0;
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end
  end

  // Write-channel control and response registers.
  always_ff @(posedge aclk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (areset) begin
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      aw_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
    end else begin
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      aw_idx_q   <= aw_idx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

  // Register storage.
  always_ff @(posedge aclk) begin
    if (areset) begin
      // NOTE: this array is a bank of flops with an architected reset value, not
      // a RAM, so resetting every entry is intended.
      for (int k = 0; k < int'(NUM_REGS); k++) begin
        reg_q[k] <= RESET_VALUE;
      end
    end else begin
      reg_q <= reg_d;
    end
  end

  assign awready    = ~aw_held_q;
  assign wready     = ~w_held_q;
  assign bvalid     = bvalid_q;
  assign bresp      = bresp_q;
  assign wr_pulse_o = wr_pulse_q;

  // ---------------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------------
  assign ar_idx = araddr[ADDR_WIDTH-1:OFF_W];

  // Select the read source for the requested index; unmatched indices are errors.
  always_comb begin
    rd_value = '0;
    rd_resp  = RESP_SLVERR;
    for (int k = 0; k < int'(NUM_REGS); k++) begin
      if (ar_idx == IDX_W'(k)) begin
        rd_resp  = RESP_OKAY;
        rd_value = RO_MASK[k] ? regs_i[k*DATA_WIDTH +: DATA_WIDTH] : reg_q[k];
      end
    end
  end

  // Accept one AR at a time, register the response, release on R handshake.
  always_comb begin
    ar_busy_d = ar_busy_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;

    if (arvalid && !ar_busy_q) begin
      ar_busy_d = 1'b1;
      rvalid_d  = 1'b1;
      rdata_d   = rd_value;
      rresp_d   = rd_resp;
    end else if (rvalid_q && rready) begin
      ar_busy_d = 1'b0;
      rvalid_d  = 1'b0;
    end
  end

  // Read-channel registers.
  always_ff @(posedge aclk) begin
    if (areset) begin
      ar_busy_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      ar_busy_q <= ar_busy_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign arready = ~ar_busy_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

  // ---------------------------------------------------------------------------
  // Register outputs: read-only slots present zero.
  // ---------------------------------------------------------------------------
  always_comb begin
    regs_o = '0;
    for (int k = 0; k < int'(NUM_REGS); k++) begin
      if (!RO_MASK[k]) begin
        regs_o[k*DATA_WIDTH +: DATA_WIDTH] = reg_q[k];
      end
    end
  end

endmodule
